// File: rtl/des_pkg.sv
// DES constant tables, widths and small permutation/rotation helpers shared by
// the round engine and its f-function.
package des_pkg;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 28;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // All tables use DES bit numbering: position 1 is the MSB of the source word.
  localparam int PC1 [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
    10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};

  localparam int PC2 [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,
    23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};

  localparam int E [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
     8, 9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,
    24,25,26,27,28,29,28,29,30,31,32, 1};

  localparam int P [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

  localparam int SHIFT_SCHED [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // 4-bit entries, indexed by {b1,b6,b2..b5} of each 6-bit group.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [55:0] pc1_perm(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1[i]];
    return o;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [2*CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] o;
    for (int i = 0; i < SUBKEY_W; i++) o[SUBKEY_W-1-i] = cd[2*CD_W-PC2[i]];
    return o;
  endfunction

  function automatic logic [SUBKEY_W-1:0] e_expand(input logic [HALF_W-1:0] r);
    logic [SUBKEY_W-1:0] o;
    for (int i = 0; i < SUBKEY_W; i++) o[SUBKEY_W-1-i] = r[HALF_W-E[i]];
    return o;
  endfunction

  function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] s);
    logic [HALF_W-1:0] o;
    for (int i = 0; i < HALF_W; i++) o[HALF_W-1-i] = s[HALF_W-P[i]];
    return o;
  endfunction

  function automatic logic [CD_W-1:0] rot_l(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rot_r(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction
endpackage

// File: rtl/des_round_engine_f_func.sv
// DES round function f(R,K) = P(S(E(R) ^ K)), purely combinational.
module des_f_func
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [HALF_W-1:0]   f
);
  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;

  assign x = e_expand(r) ^ k;

  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] six;
    assign six = x[SUBKEY_W-1-6*j -: 6];
    assign s[HALF_W-1-4*j -: 4] = 4'(SBOX[j][{six[5], six[0], six[4:1]}]);
  end

  assign f = p_perm(s);
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, key schedule rotated on the
// fly in either direction so decrypt needs no subkey storage.
module des_round_engine
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] ip_in,
  input  logic [63:0] key,
  output logic        busy,
  output logic        done,
  output logic [63:0] pre_out
);
  state_t              state_q, state_d;
  logic [HALF_W-1:0]   l_q, r_q, f_out;
  logic [CD_W-1:0]     c_q, d_q, c_rot, d_rot;
  logic [3:0]          round_cnt, dec_idx;
  logic                dec_q, load, last, two_enc, two_dec;
  logic [SUBKEY_W-1:0] kn;
  logic [63:0]         pre_q;

  // Decrypt walks the schedule backwards: 16-round_cnt wraps to 0 on round 0,
  // where no rotation is applied anyway.
  assign dec_idx = 4'd0 - round_cnt;
  assign two_enc = (SHIFT_SCHED[round_cnt] == 2);
  assign two_dec = (SHIFT_SCHED[dec_idx] == 2);
  assign last    = (round_cnt == 4'(NUM_ROUNDS - 1));

  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!dec_q) begin
      c_rot = rot_l(c_q, two_enc);
      d_rot = rot_l(d_q, two_enc);
    end else if (round_cnt != 4'd0) begin
      c_rot = rot_r(c_q, two_dec);
      d_rot = rot_r(d_q, two_dec);
    end
  end

  assign kn = pc2_perm({c_rot, d_rot});

  des_f_func u_f (.r(r_q), .k(kn), .f(f_out));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND:   if (last) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      dec_q     <= 1'b0;
      round_cnt <= '0;
      pre_q     <= '0;
    end else if (load) begin
      l_q              <= ip_in[63:32];
      r_q              <= ip_in[31:0];
      {c_q, d_q}       <= pc1_perm(key);
      dec_q            <= decrypt;
      round_cnt        <= '0;
    end else if (state_q == ROUND) begin
      l_q       <= r_q;
      r_q       <= l_q ^ f_out;
      c_q       <= c_rot;
      d_q       <= d_rot;
      round_cnt <= round_cnt + 4'd1;
      // Final swap undone: emit R16 || L16.
      if (last) pre_q <= {l_q ^ f_out, r_q};
    end
  end

  assign pre_out = pre_q;
endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: known-answer vectors, control corner
// cases, and an encrypt/decrypt round-trip sweep with start held high.
module tb_des_round_engine;
  logic        clk = 1'b0, n_rst = 1'b0, start = 1'b0, decrypt = 1'b0;
  logic [63:0] ip_in = '0, key = '0;
  logic        busy, done;
  logic [63:0] pre_out;
  int          n_checks = 0, n_errs = 0;

  localparam logic [63:0] K1    = 64'h133457799BBCDFF1;
  localparam logic [63:0] IPX   = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] PRE1  = 64'h0A4CD99543423234;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10, 2,60,52,44,36,28,20,12, 4,
    62,54,46,38,30,22,14, 6,64,56,48,40,32,24,16, 8,
    57,49,41,33,25,17, 9, 1,59,51,43,35,27,19,11, 3,
    61,53,45,37,29,21,13, 5,63,55,47,39,31,23,15, 7};

  typedef struct {
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
  } kat_t;
  kat_t kats[5];

  always #5 clk = ~clk;

  des_round_engine #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt),
    .ip_in(ip_in), .key(key), .busy(busy), .done(done), .pre_out(pre_out));

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[64-IP_T[i]] = x[63-i];
    return o;
  endfunction

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic [63:0] ip, input logic d);
    @(negedge clk);
    key = k; ip_in = ip; decrypt = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after the start pulse until done; optionally re-pulses
  // start with a different block at cycle inject_at.
  task automatic wait_done(input int inject_at, input logic [63:0] inj_ip,
                           output logic [63:0] res, output int lat, output int busy_cnt);
    lat = -1; res = '0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i; res = pre_out;
        break;
      end
      if (i == inject_at) begin start = 1'b1; ip_in = inj_ip; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (lat < 0) begin
      n_checks++; n_errs++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    logic [63:0] res, res_a, v, kk;
    int lat, bc, cnt, t, t1, last_t, nd, hold_bad;

    kats[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
    kats[1] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
    kats[2] = '{64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
    kats[3] = '{64'h0101010101010101, 64'h95F8A5E5DD31D900, 64'h8000000000000000};
    kats[4] = '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815};

    // Reset state
    repeat (2) @(negedge clk);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk64("reset_pre_out", pre_out, 64'h0);
    n_rst = 1'b1;

    // Scenario 1 with first-round internals
    pulse_start(K1, IPX, 1'b0);
    chk64("k1_subkey", {16'h0, dut.kn}, 64'h00001B02EFFC7072);
    @(negedge clk);
    chk64("round1_l", {32'h0, dut.l_q}, 64'h00000000F0AAF0AA);
    chk64("round1_r", {32'h0, dut.r_q}, 64'h00000000EF4A6544);
    wait_done(0, '0, res, lat, bc);
    chk64("kat_encrypt_pre_out", res, PRE1);

    // Scenario 2
    pulse_start(K1, PRE1, 1'b1);
    wait_done(0, '0, res, lat, bc);
    chk64("kat_decrypt_pre_out", res, IPX);
    chk_int("decrypt_latency", lat, 16);

    // Known-answer table, both directions
    for (int i = 0; i < 5; i++) begin
      pulse_start(kats[i].key, ip_perm(kats[i].pt), 1'b0);
      wait_done(0, '0, res, lat, bc);
      chk64($sformatf("kat%0d_enc", i), fp_perm(res), kats[i].ct);
      chk_int($sformatf("kat%0d_enc_latency", i), lat, 16);
      pulse_start(kats[i].key, ip_perm(kats[i].ct), 1'b1);
      wait_done(0, '0, res, lat, bc);
      chk64($sformatf("kat%0d_dec", i), fp_perm(res), kats[i].pt);
    end

    // Scenario 3: start during busy is ignored
    pulse_start(K1, IPX, 1'b0);
    wait_done(5, 64'h1122334455667788, res, lat, bc);
    chk64("busy_start_result", res, PRE1);
    chk_int("busy_start_latency", lat, 16);
    chk_int("busy_cycles", bc, 17);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk_int("busy_start_no_extra_done", cnt, 0);
    chk_int("idle_busy_low", int'(busy), 0);

    // Scenario 4: reset at round 8
    pulse_start(K1, IPX, 1'b0);
    repeat (8) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk_int("midreset_busy", int'(busy), 0);
    chk_int("midreset_done", int'(done), 0);
    chk64("midreset_pre_out", pre_out, 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk_int("midreset_no_stale_activity", cnt, 0);
    pulse_start(K1, IPX, 1'b0);
    wait_done(0, '0, res, lat, bc);
    chk64("post_reset_result", res, PRE1);
    chk_int("post_reset_latency", lat, 16);

    // Scenario 5: back-to-back, pre_out holds until the next done
    @(negedge clk);
    key = K1; ip_in = IPX; decrypt = 1'b0; start = 1'b1;
    t = 0; t1 = -1; nd = 0; hold_bad = 0; res_a = '0;
    while (nd < 2 && t < 100) begin
      @(negedge clk);
      t++;
      if (nd == 1 && !done && pre_out !== res_a) hold_bad++;
      if (done) begin
        if (nd == 0) begin
          res_a = pre_out; t1 = t;
          ip_in = PRE1; decrypt = 1'b1;
        end else begin
          chk64("b2b_second_result", pre_out, IPX);
          chk_int("b2b_spacing", t - t1, 18);
          start = 1'b0;
        end
        nd++;
      end
    end
    start = 1'b0;
    chk_int("b2b_done_count", nd, 2);
    chk64("b2b_first_result", res_a, PRE1);
    chk_int("b2b_pre_out_hold", hold_bad, 0);

    // Scenario 6: round-trip sweep, start held high, alternating direction
    repeat (3) @(negedge clk);
    kk = {$urandom, $urandom}; v = {$urandom, $urandom};
    key = kk; ip_in = v; decrypt = 1'b0; start = 1'b1;
    t = 0; last_t = -1; nd = 0;
    while (nd < 200 && t < 200 * 18 + 100) begin
      @(negedge clk);
      t++;
      if (done) begin
        if (nd > 0) chk_int($sformatf("sweep_spacing_%0d", nd), t - last_t, 18);
        last_t = t;
        if (nd % 2 == 0) begin
          ip_in = pre_out; decrypt = 1'b1;
        end else begin
          chk64($sformatf("sweep_roundtrip_%0d", nd), pre_out, v);
          kk = {$urandom, $urandom}; v = {$urandom, $urandom};
          key = kk; ip_in = v; decrypt = 1'b0;
        end
        nd++;
      end
    end
    start = 1'b0;
    chk_int("sweep_blocks", nd, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
